// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands MSB-first,
//   DIGIT bits per clock, unsigned or two's complement, and stops on the first
//   differing digit.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       compare request, accepted only while busy=0
//   signedMode  0 = unsigned, 1 = two's complement (sampled with start)
//   compared    operand A (sampled with start)
//   comparer    operand B (sampled with start)
//   busy        compare in progress
//   done        one-cycle pulse when the result becomes valid
//   lessThan    A < B
//   equalTo     A == B
//   moreThan    A > B
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] compared,
    input  logic [WIDTH-1:0] comparer,
    output logic             busy,
    output logic             done,
    output logic             lessThan,
    output logic             equalTo,
    output logic             moreThan
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
        $error("seq_magnitude_comparator: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [DIGIT-1:0] a_top;
    logic [DIGIT-1:0] b_top;

    assign a_top = a_q[WIDTH-1 -: DIGIT];
    assign b_top = b_q[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Inverting the sign bits maps two's complement onto offset
                    // binary, so the digit loop below is always unsigned.
                    a_d                = compared;
                    b_d                = comparer;
                    a_d[WIDTH-1]       = compared[WIDTH-1] ^ signedMode;
                    b_d[WIDTH-1]       = comparer[WIDTH-1] ^ signedMode;
                    cnt_d              = '0;
                    state_d            = StRun;
                    busy_d             = 1'b1;
                    lt_d               = 1'b0;
                    eq_d               = 1'b0;
                    gt_d               = 1'b0;
                end
            end
            StRun: begin
                if (a_top != b_top) begin
                    lt_d    = (a_top < b_top);
                    gt_d    = (a_top > b_top);
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == LAST) begin
                    eq_d    = 1'b1;
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lessThan = lt_q;
    assign equalTo  = eq_q;
    assign moreThan = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: one instance with DIGIT=1 and one with
// DIGIT=4. Stimulus pushes expected flags and due cycle into a queue; monitors
// pop and compare whenever done is seen.
module tb_seq_magnitude_comparator;

    typedef struct {
        logic [2:0] flags;  // {lt, eq, gt}
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic busy1, done1, lt1, eq1, gt1;
    logic busy4, done4, lt4, eq4, gt4;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .signedMode(sm),
        .compared(a), .comparer(b), .busy(busy1), .done(done1),
        .lessThan(lt1), .equalTo(eq1), .moreThan(gt1)
    );

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signedMode(sm),
        .compared(a), .comparer(b), .busy(busy4), .done(done4),
        .lessThan(lt4), .equalTo(eq4), .moreThan(gt4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the DIGIT=1 instance
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (busy1) chk("busy1_flags_clear", {lt1, eq1, gt1}, 3'b000);
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("spurious_done1", done1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk("result1", {lt1, eq1, gt1}, e1.flags);
                    chk("latency1", cyc, e1.due);
                    chk("busy1_at_done", busy1, 0);
                end
            end
        end
    end

    // Monitor for the DIGIT=4 instance
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (busy4) chk("busy4_flags_clear", {lt4, eq4, gt4}, 3'b000);
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("spurious_done4", done4, 0);
                end else begin
                    e4 = q4.pop_front();
                    chk("result4", {lt4, eq4, gt4}, e4.flags);
                    chk("latency4", cyc, e4.due);
                    chk("busy4_at_done", busy4, 0);
                end
            end
        end
    end

    // Called #1 after a rising edge; start is sampled on the next edge (E0).
    task automatic run_cmp(input bit d4, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ism, input logic [2:0] ef, input int k);
        exp_t e;
        a  = ia;
        b  = ib;
        sm = ism;
        if (d4) start4 = 1'b1;
        else    start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        chk(d4 ? "accept4" : "accept1", d4 ? busy4 : busy1, 1);
        e.flags = ef;
        e.due   = cyc + k;
        if (d4) q4.push_back(e);
        else    q1.push_back(e);
    endtask

    task automatic wait_done(input bit d4);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (d4 ? done4 : done1) seen = 1'b1;
        end
        if (!seen) chk(d4 ? "timeout4" : "timeout1", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_outputs1", {busy1, done1, lt1, eq1, gt1}, 5'b0);
        chk("reset_outputs4", {busy4, done4, lt4, eq4, gt4}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Equal operands run the full 8 digits; result holds afterwards.
        run_cmp(1'b0, 8'h3C, 8'h3C, 1'b0, 3'b010, 8);
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_eq", {lt1, eq1, gt1}, 3'b010);
        chk("done_one_cycle", {done1, busy1}, 2'b00);

        // MSB decides: unsigned 0x80 > 0x7F, signed -128 < 127.
        run_cmp(1'b0, 8'h80, 8'h7F, 1'b0, 3'b001, 1);
        wait_done(1'b0);
        run_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 3'b100, 1);
        wait_done(1'b0);

        // LSB decides.
        run_cmp(1'b0, 8'h12, 8'h13, 1'b0, 3'b100, 8);
        wait_done(1'b0);
        run_cmp(1'b0, 8'hFF, 8'hFE, 1'b1, 3'b001, 8);
        wait_done(1'b0);

        // Nibble-wide digits.
        run_cmp(1'b1, 8'hA5, 8'hA6, 1'b0, 3'b100, 2);
        wait_done(1'b1);
        run_cmp(1'b1, 8'hB0, 8'hA0, 1'b0, 3'b001, 1);
        wait_done(1'b1);
        run_cmp(1'b1, 8'h80, 8'h7F, 1'b1, 3'b100, 1);
        wait_done(1'b1);
        run_cmp(1'b1, 8'h5A, 8'h5A, 1'b0, 3'b010, 2);
        wait_done(1'b1);

        // Start during a running compare is ignored.
        run_cmp(1'b0, 8'h12, 8'h13, 1'b0, 3'b100, 8);
        a      = 8'hFF;
        b      = 8'h00;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1'b0);
        // Start in the done cycle is accepted with no gap.
        run_cmp(1'b0, 8'h40, 8'h20, 1'b0, 3'b001, 2);
        wait_done(1'b0);

        // Asynchronous reset in the middle of a compare.
        run_cmp(1'b0, 8'h12, 8'h13, 1'b0, 3'b100, 8);
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {busy1, done1, lt1, eq1, gt1}, 5'b0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) chk("idle_after_reset", {busy1, done1}, 2'b00);
        end
        chk("idle_after_reset_flags", {busy1, done1, lt1, eq1, gt1}, 5'b0);
        run_cmp(1'b0, 8'h05, 8'h05, 1'b0, 3'b010, 8);
        wait_done(1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue1_drained", q1.size(), 0);
        chk("queue4_drained", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
